// File: rtl/beep_pkg.sv
// Shared note indices, decoder states and reference-period helper for the
// beep tone decoder.
package beep_pkg;

   localparam logic [2:0] NOTE_SIL = 3'd0;
   localparam logic [2:0] NOTE_DO  = 3'd1;
   localparam logic [2:0] NOTE_RE  = 3'd2;
   localparam logic [2:0] NOTE_MI  = 3'd3;
   localparam logic [2:0] NOTE_FA  = 3'd4;
   localparam logic [2:0] NOTE_SOL = 3'd5;
   localparam logic [2:0] NOTE_LA  = 3'd6;
   localparam logic [2:0] NOTE_SI  = 3'd7;

   localparam int unsigned NOTE_HZ [1:7] = '{262, 294, 330, 349, 392, 440, 494};

   typedef enum logic [1:0] {
      ST_SILENT,
      ST_ACQUIRE,
      ST_LOCKED
   } state_t;

   function automatic int unsigned ref_period(input int unsigned clk_hz,
                                              input int unsigned idx);
      return clk_hz / NOTE_HZ[idx];
   endfunction

endpackage

// File: rtl/beep_sync_edge.sv
// Two-flop synchronizer for the asynchronous beep line plus a registered
// rising-edge strobe.
module beep_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic beep,
   output logic rise
);

   logic s1;
   logic s2;
   logic s2_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         s2_d <= 1'b0;
         rise <= 1'b0;
      end else begin
         s1   <= beep;
         s2   <= s1;
         s2_d <= s2;
         rise <= s2 & ~s2_d;
      end
   end

endmodule

// File: rtl/beep_decoder.sv
// Measures the rising-to-rising period of the buzzer square wave and locks
// onto one of the seven scale notes after consecutive matching periods.
module beep_decoder
   import beep_pkg::*;
#(
   parameter int unsigned CLK_HZ    = 50_000_000,
   parameter int unsigned PERIOD_W  = 20,
   parameter int unsigned TOL_SHIFT = 5,
   parameter int unsigned MATCH_CNT = 2,
   parameter int unsigned TIMEOUT   = CLK_HZ / 50
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                beep,
   output logic [2:0]          note,
   output logic                note_valid,
   output logic                note_start,
   output logic [PERIOD_W-1:0] period
);

   localparam int unsigned MW = $clog2(MATCH_CNT + 1) + 1;

   localparam int unsigned REF_P [1:7] = '{
      ref_period(CLK_HZ, 1), ref_period(CLK_HZ, 2), ref_period(CLK_HZ, 3),
      ref_period(CLK_HZ, 4), ref_period(CLK_HZ, 5), ref_period(CLK_HZ, 6),
      ref_period(CLK_HZ, 7)
   };

   // A saturated counter must never fall inside any note's tolerance window.
   for (genvar g = 1; g <= 7; g++) begin : g_ref_chk
      if ((longint'(REF_P[g]) + longint'(REF_P[g] >> TOL_SHIFT)) >=
          ((longint'(1) << PERIOD_W) - 1)) begin : g_bad
         $error("beep_decoder: note reference period does not fit PERIOD_W");
      end
   end

   if (longint'(TIMEOUT) >= ((longint'(1) << PERIOD_W) - 1)) begin : g_to_chk
      $error("beep_decoder: TIMEOUT does not fit PERIOD_W");
   end

   logic                rise;
   state_t              state;
   logic [PERIOD_W-1:0] cnt;
   logic [2:0]          cand;
   logic [2:0]          idx;
   logic [MW-1:0]       mcnt;
   logic [MW-1:0]       acq_cnt;

   beep_sync_edge u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .beep  (beep),
      .rise  (rise)
   );

   // Classifies the period about to be latched; descending scan so the
   // lowest matching index is the one left in idx.
   always_comb begin
      logic [PERIOD_W:0] p;
      logic [PERIOD_W:0] r;
      logic [PERIOD_W:0] d;
      idx = NOTE_SIL;
      p   = {1'b0, cnt};
      r   = '0;
      d   = '0;
      for (int unsigned i = 7; i >= 1; i--) begin
         r = (PERIOD_W + 1)'(REF_P[i]);
         d = (p >= r) ? (p - r) : (r - p);
         if (d <= (r >> TOL_SHIFT)) begin
            idx = 3'(i);
         end
      end
   end

   always_comb begin
      acq_cnt = '0;
      if (idx == NOTE_SIL) begin
         acq_cnt = '0;
      end else if (idx == cand) begin
         acq_cnt = mcnt + MW'(1);
      end else begin
         acq_cnt = MW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_SILENT;
         cnt        <= '0;
         period     <= '0;
         note       <= NOTE_SIL;
         note_valid <= 1'b0;
         note_start <= 1'b0;
         cand       <= NOTE_SIL;
         mcnt       <= '0;
      end else begin
         note_start <= 1'b0;
         if (cnt != '1) begin
            cnt <= cnt + PERIOD_W'(1);
         end
         if (rise) begin
            cnt <= PERIOD_W'(1);
            case (state)
               ST_SILENT: begin
                  state <= ST_ACQUIRE;
                  cand  <= NOTE_SIL;
                  mcnt  <= '0;
               end
               ST_ACQUIRE: begin
                  period <= cnt;
                  cand   <= idx;
                  mcnt   <= acq_cnt;
                  if (acq_cnt >= MW'(MATCH_CNT)) begin
                     state      <= ST_LOCKED;
                     note       <= idx;
                     note_valid <= 1'b1;
                     note_start <= 1'b1;
                  end
               end
               ST_LOCKED: begin
                  period <= cnt;
                  if (idx != note) begin
                     state      <= ST_ACQUIRE;
                     note       <= NOTE_SIL;
                     note_valid <= 1'b0;
                     cand       <= idx;
                     mcnt       <= (idx != NOTE_SIL) ? MW'(1) : '0;
                  end
               end
               default: state <= ST_SILENT;
            endcase
         end else if (cnt == PERIOD_W'(TIMEOUT)) begin
            state      <= ST_SILENT;
            note       <= NOTE_SIL;
            note_valid <= 1'b0;
            cand       <= NOTE_SIL;
            mcnt       <= '0;
         end
      end
   end

endmodule

// File: tb/tb_beep_decoder.sv
// Bench for beep_decoder: directed note/timeout/reset sequences, a tolerance
// table and randomized periods checked against a period-history model.
module tb_beep_decoder;

   localparam int unsigned CLK_HZ = 1_000_000;
   localparam int unsigned PW     = 20;
   localparam int unsigned TO     = 20_000;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          beep  = 1'b0;
   logic [2:0]    note;
   logic          note_valid;
   logic          note_start;
   logic [PW-1:0] period;

   beep_decoder #(
      .CLK_HZ    (CLK_HZ),
      .PERIOD_W  (PW),
      .TOL_SHIFT (5),
      .MATCH_CNT (2),
      .TIMEOUT   (TO)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .beep       (beep),
      .note       (note),
      .note_valid (note_valid),
      .note_start (note_start),
      .period     (period)
   );

   always #5 clk = ~clk;

   int total       = 0;
   int bad         = 0;
   int cyc         = 0;
   int starts_seen = 0;

   int ref_tab [1:7] = '{3816, 3401, 3030, 2865, 2551, 2272, 2024};

   // Model: history of classified periods since the last silence/reset.
   bit m_active     = 1'b0;
   int m_hist [$];
   int last_rise    = 0;
   int m_period     = 0;
   int m_note       = 0;
   int m_valid      = 0;
   int m_prev_valid = 0;
   int m_starts     = 0;

   typedef struct {
      int per;
      int exp_note;
      int exp_valid;
   } vec_t;

   function automatic int classify(input int p);
      for (int i = 1; i <= 7; i++) begin
         if (p >= ref_tab[i] - ref_tab[i] / 32 && p <= ref_tab[i] + ref_tab[i] / 32)
            return i;
      end
      return 0;
   endfunction

   task automatic model_rise(input int t);
      int run;
      m_prev_valid = m_valid;
      if (!m_active) begin
         m_active = 1'b1;
         m_hist.delete();
      end else begin
         m_period = t - last_rise;
         m_hist.push_back(classify(m_period));
      end
      last_rise = t;
      run = 0;
      if (m_hist.size() > 0 && m_hist[$] != 0) begin
         for (int i = m_hist.size() - 1; i >= 0; i--) begin
            if (m_hist[i] != m_hist[$]) break;
            run++;
         end
      end
      m_valid = (run >= 2) ? 1 : 0;
      m_note  = m_valid ? m_hist[$] : 0;
      if (run == 2) m_starts++;
   endtask

   task automatic model_silence();
      m_active = 1'b0;
      m_hist.delete();
      m_note   = 0;
      m_valid  = 0;
   endtask

   task automatic model_reset();
      model_silence();
      m_period = 0;
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (note_start === 1'b1) begin
         starts_seen++;
         total++;
         if (note == 3'd0) begin
            bad++;
            $display("FAIL start_note: got %0d, required nonzero", note);
         end
      end
   end

   // One rising edge, held high for hi cycles; outputs checked 3 edges later.
   task automatic do_rise(input int hi, input bit lat);
      beep = 1'b1;
      model_rise(cyc);
      tick(3);
      if (lat) chk("lat_valid_hold", note_valid, m_prev_valid);
      tick(1);
      chk("period", period, m_period);
      chk("note", note, m_note);
      chk("valid", note_valid, m_valid);
      tick(hi - 4);
      beep = 1'b0;
   endtask

   task automatic play(input int per, input int n, input int gap);
      tick(gap);
      for (int r = 0; r < n; r++) begin
         do_rise(per / 2, 1'b0);
         if (r != n - 1) tick(per - per / 2);
      end
   endtask

   task automatic do_reset();
      beep  = 1'b0;
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tv [3];
      int   starts_before;
      int   per;
      int   k;
      int   w;

      tv[0] = '{per: 2343, exp_note: 6, exp_valid: 1};
      tv[1] = '{per: 2344, exp_note: 0, exp_valid: 0};
      tv[2] = '{per: 1961, exp_note: 7, exp_valid: 1};

      // Reset with beep toggling, then idle.
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         beep = ~beep;
         tick(1);
         chk("rst_note", note, 0);
         chk("rst_valid", note_valid, 0);
         chk("rst_period", period, 0);
      end
      beep  = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         chk("idle_note", note, 0);
         chk("idle_valid", note_valid, 0);
         chk("idle_start", note_start, 0);
      end

      // Lock on la with the latency check on the third edge.
      play(2272, 2, 10);
      tick(2272 - 1136);
      do_rise(1136, 1'b1);
      chk("la_note", note, 6);
      chk("la_valid", note_valid, 1);
      chk("la_period", period, 2272);
      chk("la_starts", starts_seen, 1);

      // Note change la -> mi.
      play(3030, 1, 3030 - 1136);
      chk("chg_valid_drop", note_valid, 0);
      play(3030, 1, 3030 - 1515);
      chk("chg_note", note, 3);
      chk("chg_valid", note_valid, 1);
      chk("chg_starts", starts_seen, 2);

      // Timeout after beep stops low.
      tick(last_rise + TO + 3 - cyc);
      chk("to_hold_valid", note_valid, 1);
      tick(1);
      chk("to_valid", note_valid, 0);
      chk("to_note", note, 0);
      chk("to_period", period, 3030);
      model_silence();
      play(2551, 3, 0);
      chk("restart_note", note, 5);

      // Tolerance table.
      for (int i = 0; i < 3; i++) begin
         do_reset();
         play(tv[i].per, 3, 10);
         chk("tab_note", note, tv[i].exp_note);
         chk("tab_valid", note_valid, tv[i].exp_valid);
         chk("tab_period", period, tv[i].per);
      end

      // Reset while locked on do.
      do_reset();
      play(3816, 3, 10);
      chk("do_note", note, 1);
      starts_before = starts_seen;
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      chk("mid_rst_note", note, 0);
      chk("mid_rst_valid", note_valid, 0);
      chk("mid_rst_period", period, 0);
      chk("mid_rst_start", note_start, 0);
      model_reset();
      play(3816, 2, 100);
      chk("relock_wait", note_valid, 0);
      chk("relock_no_start", starts_seen, starts_before);
      play(3816, 1, 3816 - 1908);
      chk("relock_note", note, 1);

      // Randomized periods, near-note and arbitrary.
      for (int s = 0; s < 3; s++) begin
         if ($urandom_range(0, 1) == 1) begin
            k   = int'($urandom_range(1, 7));
            w   = ref_tab[k] / 32 + 4;
            per = ref_tab[k] + int'($urandom_range(0, 2 * w)) - w;
         end else begin
            per = int'($urandom_range(1900, 4000));
         end
         play(per, 2, per - per / 2);
      end

      tick(5);
      chk("start_count", starts_seen, m_starts);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/beep_decoder.md
# beep_decoder

Tone receiver for the buzzer path: samples the square-wave `beep` line that the `Music` player drives, measures its period in `clk` cycles and classifies it as one of the seven scale notes (do…si) or silence. Sits on the far side of the buzzer interface, used in self-check builds and benches to confirm what the melody generator actually plays. Reports the current note, a valid flag, a one-cycle note-start strobe and the raw measured period.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000, `clk` frequency in Hz; note reference periods are derived from it at elaboration.
- `PERIOD_W`, 20, width of period counter and `period` output.
- `TOL_SHIFT`, 5, match tolerance is `ref >> TOL_SHIFT` (≈3 %).
- `MATCH_CNT`, 2, consecutive matching periods needed to lock.
- `TIMEOUT`, `CLK_HZ/50`, cycles without a rising edge before declaring silence.

Ports:
- `clk` in 1, system clock.
- `rst_n` in 1, synchronous active-low reset (one clock; reset is synchronous and active-low).
- `beep` in 1, asynchronous square wave from the buzzer driver.
- `note` out 3, 0 = silence, 1..7 = do, re, mi, fa, sol, la, si.
- `note_valid` out 1, high while locked on a note.
- `note_start` out 1, one-cycle pulse on lock or note change.
- `period` out `PERIOD_W`, last measured rising-to-rising period in cycles.

## Operation
- `beep` passes a 2-flop synchronizer; rising edge = sync2 high and previous sync2 low.
- Period counter increments every cycle, saturates at all-ones; on a rising edge it is latched into `period` and restarted at 1.
- First edge after SILENT only starts measurement; no period latched, no classification.
- Classification: index i (1..7) matches if |period − REF[i]| ≤ REF[i] >> TOL_SHIFT; lowest matching i wins; no match = 0. Compare is unsigned with `PERIOD_W+1`-bit difference.
- FSM:
  - SILENT: outputs note=0, valid=0. Rising edge → ACQUIRE (match count 0).
  - ACQUIRE: each latched period: match equal to candidate → count+1, else candidate = new index, count = (index≠0). count reaching MATCH_CNT → LOCKED, note=candidate, valid=1, note_start=1.
  - LOCKED: period matching current note → stay. Matching a different note → candidate=new, count=1, ACQUIRE, valid=0. No match → ACQUIRE, count 0, valid=0.
  - Any state: counter reaching TIMEOUT with no edge → SILENT same cycle counter hits TIMEOUT.
- Rising edge and timeout in same cycle: edge wins (counter restarts).
- Saturated period never matches (all REF < 2^PERIOD_W required; elaboration check).

## Timing
- Reset (synchronous, `rst_n`=0 at a `clk` edge): state SILENT, note=0, note_valid=0, note_start=0, period=0, counter=0, sync flops=0.
- Reset mid-lock: outputs return to reset values at that edge, no note_start.
- Latency: `beep` rise first sampled at edge k → edge detected at k+2 → `period`, `note`, `note_valid`, `note_start` registered at edge k+3.
- `note_start` high exactly one cycle; never asserted with note=0.
- Timeout: `note_valid` falls on the edge where counter == TIMEOUT.

## Structure
- Package `beep_pkg`: note index localparams (NOTE_SIL…NOTE_SI), NOTE_HZ array {262,294,330,349,392,440,494}, state typedef, function `ref_period(clk_hz, idx) = clk_hz / NOTE_HZ[idx]` (integer truncate).
- Sub-module `beep_sync_edge`: 2-flop synchronizer plus rising-edge detector. Rest (counter, classifier, FSM) in `beep_decoder`.

## Test plan
All with CLK_HZ=1_000_000 (REF: 3816, 3401, 3030, 2865, 2551, 2272, 2024), TIMEOUT=20_000, MATCH_CNT=2.
- Reset: `rst_n`=0 for 3 cycles, `beep` toggling → note=0, valid=0, period=0 throughout; held after release until activity.
- Lock la: 2272-cycle square wave → note=6, valid=1 after third rising edge + 3 cycles, single note_start, period=2272.
- Tolerance edges: period 2272+71=2343 → locks la; 2272+72=2344 → never valid, note stays 0.
- Note change: la locked, switch to 3030 period → valid drops on first 3030 period, relocks note=3 after second, one new note_start.
- Timeout: stop `beep` low while locked → valid=0, note=0 exactly 20_000 cycles after last latched edge; restart with 2551 → note=5.
- Reset mid-lock on do (3816) → outputs zero next edge, no note_start; relock requires fresh 3 edges.
